// File: rtl/exit_monitor.sv
// rtl/exit_monitor.sv - exit strobe consumer with run-cycle counter, watchdog, drain window and sticky verdict
// Optional build macro: EXIT_MONITOR_FINISH_EN (prints the verdict and ends simulation on entry to DONE)
module exit_monitor #(
  parameter int XLEN           = 64,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exit_i,
  input  logic [XLEN-1:0]  exit_code_i,
  output logic             halt_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  result_code_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic             to_flag;
  logic             wd_hit;
  logic             capture;
  logic             enter_done;
  logic [XLEN-1:0]  cap_code;
  logic             cap_to;
  logic [XLEN-1:0]  done_code;
  logic             done_to;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state decode plus the capture/verdict values that feed the output registers
  always_comb begin
    state_next = state;
    wd_hit     = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    capture    = 1'b0;
    enter_done = 1'b0;
    cap_code   = exit_i ? exit_code_i : '1;
    cap_to     = !exit_i;
    case (state)
      RUN: begin
        if (exit_i || wd_hit) begin
          capture = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          state_next = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_next = DONE;
    endcase
    // With no drain window the verdict is formed from the values being captured this edge
    done_code = (state == RUN) ? cap_code : result_code_o;
    done_to   = (state == RUN) ? cap_to   : to_flag;
  end

  // Counters, captured values and sticky verdict outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      dcnt          <= '0;
      to_flag       <= 1'b0;
      halt_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      timeout_o     <= 1'b0;
      result_code_o <= '0;
      cycles_o      <= '0;
    end else begin
      if (state == RUN && cnt != '1) cnt <= cnt + 1'b1;
      if (capture) begin
        result_code_o <= cap_code;
        cycles_o      <= cnt;
        to_flag       <= cap_to;
        halt_o        <= 1'b1;
        dcnt          <= DRAIN_LAST;
      end else if (state == DRAIN && dcnt != '0) begin
        dcnt <= dcnt - 1'b1;
      end
      if (enter_done) begin
        done_o    <= 1'b1;
        pass_o    <= (done_code == '0) && !done_to;
        fail_o    <= !((done_code == '0) && !done_to);
        timeout_o <= done_to;
      end
    end
  end

`ifdef EXIT_MONITOR_FINISH_EN
  logic finish_pending;

  // Report the verdict on entry to DONE and end the simulation one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      finish_pending <= 1'b0;
    end else if (finish_pending) begin
      $finish;
    end else if (enter_done) begin
      finish_pending <= 1'b1;
      $display("EXIT code=%0d cycles=%0d %s", done_code,
               (state == RUN) ? cnt : cycles_o,
               done_to ? "TIMEOUT" : ((done_code == '0) ? "PASS" : "FAIL"));
    end
  end
`else
  // Synthesis build: verdict is reported only through the ports
`endif

endmodule

// File: tb/tb_exit_monitor.sv
// tb/tb_exit_monitor.sv - directed self-checking bench for exit_monitor
module tb_exit_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        exit_i;
  logic [63:0] exit_code_i;
  logic        halt_o, done_o, pass_o, fail_o, timeout_o;
  logic [63:0] result_code_o;
  logic [31:0] cycles_o;

  int vectors = 0;
  int errors  = 0;

  exit_monitor #(
    .XLEN(64), .CNT_W(32), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .exit_i(exit_i), .exit_code_i(exit_code_i),
    .halt_o(halt_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .timeout_o(timeout_o), .result_code_o(result_code_o), .cycles_o(cycles_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  // Wait n cycles in RUN, then present one exit strobe with the given code
  task automatic run_exit(input int n, input logic [63:0] code);
    tick(n);
    exit_i      = 1'b1;
    exit_code_i = code;
    tick(1);
    exit_i      = 1'b0;
    exit_code_i = '0;
  endtask

  task automatic chk_verdict(input string tag, input logic d, input logic p,
                             input logic f, input logic t);
    chk({tag, "_done"},    done_o,    d);
    chk({tag, "_pass"},    pass_o,    p);
    chk({tag, "_fail"},    fail_o,    f);
    chk({tag, "_timeout"}, timeout_o, t);
  endtask

  initial begin
    rst = 1'b1; exit_i = 1'b0; exit_code_i = '0;
    @(posedge clk); #1;

    // 1. exit code 42 at cnt=20
    do_reset();
    chk("rst_halt", halt_o, 1'b0);
    chk_verdict("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_code", result_code_o, 64'd0);
    chk("rst_cycles", cycles_o, 64'd0);
    run_exit(20, 64'd42);
    chk("t1_halt", halt_o, 1'b1);
    chk("t1_done_early", done_o, 1'b0);
    tick(3);
    chk("t1_done_at3", done_o, 1'b0);
    chk("t1_fail_at3", fail_o, 1'b0);
    tick(1);
    chk_verdict("t1", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_code", result_code_o, 64'd42);
    chk("t1_cycles", cycles_o, 64'd20);

    // 2. exit code 0 at cnt=20
    do_reset();
    run_exit(20, 64'd0);
    chk("t2_halt", halt_o, 1'b1);
    tick(4);
    chk_verdict("t2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_cycles", cycles_o, 64'd20);

    // 3. watchdog expiry
    do_reset();
    tick(99);
    chk("t3_halt_pre", halt_o, 1'b0);
    tick(1);
    chk("t3_halt", halt_o, 1'b1);
    chk("t3_code", result_code_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_cycles", cycles_o, 64'd99);
    chk("t3_timeout_early", timeout_o, 1'b0);
    tick(3);
    chk("t3_done_at3", done_o, 1'b0);
    tick(1);
    chk_verdict("t3", 1'b1, 1'b0, 1'b1, 1'b1);

    // 4. exit and watchdog on the same edge: exit wins
    do_reset();
    run_exit(99, 64'd5);
    chk("t4_halt", halt_o, 1'b1);
    tick(4);
    chk_verdict("t4", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_code", result_code_o, 64'd5);
    chk("t4_cycles", cycles_o, 64'd99);

    // 5. exit during DRAIN is ignored
    do_reset();
    run_exit(20, 64'd42);
    tick(1);
    exit_i = 1'b1; exit_code_i = 64'd7;
    tick(1);
    exit_i = 1'b0; exit_code_i = '0;
    tick(1);
    chk("t5_done_at3", done_o, 1'b0);
    chk("t5_code_drain", result_code_o, 64'd42);
    tick(1);
    chk_verdict("t5", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_code", result_code_o, 64'd42);
    chk("t5_cycles", cycles_o, 64'd20);

    // 6. reset mid-DRAIN, then a fresh passing run
    do_reset();
    run_exit(20, 64'd42);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_halt_rst", halt_o, 1'b0);
    chk_verdict("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_code_rst", result_code_o, 64'd0);
    chk("t6_cycles_rst", cycles_o, 64'd0);
    run_exit(10, 64'd0);
    chk("t6_halt", halt_o, 1'b1);
    tick(4);
    chk_verdict("t6", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_cycles", cycles_o, 64'd10);

    // Verdict stays sticky in DONE
    exit_i = 1'b1; exit_code_i = 64'd9;
    tick(5);
    exit_i = 1'b0;
    chk_verdict("sticky", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sticky_halt", halt_o, 1'b1);
    chk("sticky_code", result_code_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
